// File: rtl/swi_debounce.sv
// Switch input conditioner: 2-flop synchroniser, per-bit debounce counter, rise/fall/changed pulses.
// Optional per-bit push-on/push-off latch on swi_toggle, enabled by defining SWI_TOGGLE_EN.
module swi_debounce #(
    parameter int NBITS           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic [NBITS-1:0] swi_raw,
    output logic [NBITS-1:0] swi_stable,
    output logic [NBITS-1:0] swi_rise,
    output logic [NBITS-1:0] swi_fall,
    output logic             swi_changed,
    output logic [NBITS-1:0] swi_toggle
);

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

    logic [NBITS-1:0] sync0;
    logic [NBITS-1:0] sync1;
    logic [NBITS-1:0] accept;
    logic [CW-1:0]    cnt [NBITS];

    // A bit is accepted on the cycle its counter reaches terminal count while still differing.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NBITS; i++) begin
            accept[i] = (sync1[i] != swi_stable[i]) && (cnt[i] == CNT_TC);
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            sync0       <= '0;
            sync1       <= '0;
            swi_stable  <= '0;
            swi_rise    <= '0;
            swi_fall    <= '0;
            swi_changed <= 1'b0;
            for (int i = 0; i < NBITS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync0 <= swi_raw;
            sync1 <= sync0;
            for (int i = 0; i < NBITS; i++) begin
                if ((sync1[i] == swi_stable[i]) || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            swi_stable  <= swi_stable ^ accept;
            swi_rise    <= accept & sync1;
            swi_fall    <= accept & ~sync1;
            swi_changed <= |accept;
        end
    end

`ifdef SWI_TOGGLE_EN
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            swi_toggle <= '0;
        end else begin
            swi_toggle <= swi_toggle ^ (accept & sync1);
        end
    end
`else
    assign swi_toggle = '0;
`endif

endmodule

// File: tb/tb_swi_debounce.sv
// Directed self-checking bench for swi_debounce; a second instance covers DEBOUNCE_CYCLES=1.
// Honours SWI_TOGGLE_EN when the bench and RTL are built with it defined.
`timescale 1ns/1ps
module tb_swi_debounce;

    logic       clk_2 = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] swi_raw = 8'h00;
    logic [7:0] swi_stable, swi_rise, swi_fall, swi_toggle;
    logic       swi_changed;
    logic [7:0] stable1, rise1, fall1, toggle1;
    logic       changed1;

    int checks = 0;
    int errors = 0;

    always #5 clk_2 = ~clk_2;

    swi_debounce #(.NBITS(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk_2(clk_2), .reset_n(reset_n), .swi_raw(swi_raw),
        .swi_stable(swi_stable), .swi_rise(swi_rise), .swi_fall(swi_fall),
        .swi_changed(swi_changed), .swi_toggle(swi_toggle)
    );

    swi_debounce #(.NBITS(8), .DEBOUNCE_CYCLES(1)) dut_min (
        .clk_2(clk_2), .reset_n(reset_n), .swi_raw(swi_raw),
        .swi_stable(stable1), .swi_rise(rise1), .swi_fall(fall1),
        .swi_changed(changed1), .swi_toggle(toggle1)
    );

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_2);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        swi_raw = 8'hFF;
        tick(4);
        checks++;
        if ({swi_stable, swi_rise, swi_fall, swi_changed, swi_toggle} !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h/%h/%h/%b/%h want 0", swi_stable, swi_rise, swi_fall, swi_changed, swi_toggle);
        end
        reset_n = 1'b1;
        tick(5);
        checks++;
        if (swi_stable !== 8'h00) begin
            errors++;
            $display("FAIL reset_edge5_stable got %h want 00", swi_stable);
        end
        tick(1);
        checks++;
        if (swi_stable !== 8'hFF || swi_rise !== 8'hFF || swi_fall !== 8'h00 || swi_changed !== 1'b1) begin
            errors++;
            $display("FAIL reset_edge6 got stable %h rise %h fall %h chg %b want FF FF 00 1", swi_stable, swi_rise, swi_fall, swi_changed);
        end
        tick(1);
        checks++;
        if (swi_rise !== 8'h00 || swi_changed !== 1'b0 || swi_stable !== 8'hFF) begin
            errors++;
            $display("FAIL reset_edge7 got stable %h rise %h chg %b want FF 00 0", swi_stable, swi_rise, swi_changed);
        end
    endtask

    task automatic test_clean_press;
        swi_raw = 8'h00;
        tick(10);
        checks++;
        if (swi_stable !== 8'h00) begin
            errors++;
            $display("FAIL press_settle got %h want 00", swi_stable);
        end
        swi_raw = 8'h01;
        tick(5);
        checks++;
        if (swi_stable !== 8'h00 || swi_rise !== 8'h00) begin
            errors++;
            $display("FAIL press_edge5 got stable %h rise %h want 00 00", swi_stable, swi_rise);
        end
        tick(1);
        checks++;
        if (swi_stable !== 8'h01 || swi_rise !== 8'h01 || swi_fall !== 8'h00 || swi_changed !== 1'b1) begin
            errors++;
            $display("FAIL press_edge6 got stable %h rise %h fall %h chg %b want 01 01 00 1", swi_stable, swi_rise, swi_fall, swi_changed);
        end
        tick(1);
        checks++;
        if (swi_rise !== 8'h00 || swi_changed !== 1'b0) begin
            errors++;
            $display("FAIL press_edge7 got rise %h chg %b want 00 0", swi_rise, swi_changed);
        end
        swi_raw = 8'h00;
        tick(5);
        checks++;
        if (swi_stable !== 8'h01 || swi_fall !== 8'h00) begin
            errors++;
            $display("FAIL release_edge5 got stable %h fall %h want 01 00", swi_stable, swi_fall);
        end
        tick(1);
        checks++;
        if (swi_stable !== 8'h00 || swi_fall !== 8'h01 || swi_rise !== 8'h00 || swi_changed !== 1'b1) begin
            errors++;
            $display("FAIL release_edge6 got stable %h fall %h rise %h chg %b want 00 01 00 1", swi_stable, swi_fall, swi_rise, swi_changed);
        end
        tick(1);
        checks++;
        if (swi_fall !== 8'h00 || swi_changed !== 1'b0) begin
            errors++;
            $display("FAIL release_edge7 got fall %h chg %b want 00 0", swi_fall, swi_changed);
        end
    endtask

    task automatic test_glitch;
        swi_raw = 8'h08;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) swi_raw = 8'h00;
            tick(1);
            checks++;
            if (swi_stable !== 8'h00 || swi_rise !== 8'h00 || swi_changed !== 1'b0) begin
                errors++;
                $display("FAIL glitch3_cycle%0d got stable %h rise %h chg %b want 00 00 0", k, swi_stable, swi_rise, swi_changed);
            end
        end
        swi_raw = 8'h08;
        tick(4);
        swi_raw = 8'h00;
        tick(1);
        checks++;
        if (swi_stable !== 8'h00) begin
            errors++;
            $display("FAIL glitch4_edge5 got %h want 00", swi_stable);
        end
        tick(1);
        checks++;
        if (swi_stable !== 8'h08 || swi_rise !== 8'h08 || swi_changed !== 1'b1) begin
            errors++;
            $display("FAIL glitch4_edge6 got stable %h rise %h chg %b want 08 08 1", swi_stable, swi_rise, swi_changed);
        end
        tick(10);
        checks++;
        if (swi_stable !== 8'h00) begin
            errors++;
            $display("FAIL glitch4_settle got %h want 00", swi_stable);
        end
    endtask

    task automatic test_simultaneous;
        swi_raw = 8'h80;
        tick(8);
        checks++;
        if (swi_stable !== 8'h80) begin
            errors++;
            $display("FAIL simul_setup got %h want 80", swi_stable);
        end
        swi_raw = 8'h01;
        tick(5);
        checks++;
        if (swi_stable !== 8'h80 || swi_changed !== 1'b0) begin
            errors++;
            $display("FAIL simul_edge5 got stable %h chg %b want 80 0", swi_stable, swi_changed);
        end
        tick(1);
        checks++;
        if (swi_stable !== 8'h01 || swi_rise !== 8'h01 || swi_fall !== 8'h80 || swi_changed !== 1'b1) begin
            errors++;
            $display("FAIL simul_edge6 got stable %h rise %h fall %h chg %b want 01 01 80 1", swi_stable, swi_rise, swi_fall, swi_changed);
        end
        tick(1);
        checks++;
        if (swi_rise !== 8'h00 || swi_fall !== 8'h00 || swi_changed !== 1'b0) begin
            errors++;
            $display("FAIL simul_edge7 got rise %h fall %h chg %b want 00 00 0", swi_rise, swi_fall, swi_changed);
        end
    endtask

    task automatic test_reset_midcount;
        swi_raw = 8'h00;
        tick(10);
        swi_raw = 8'h04;
        tick(3);
        reset_n = 1'b0;
        tick(1);
        checks++;
        if (swi_stable !== 8'h00 || swi_rise !== 8'h00) begin
            errors++;
            $display("FAIL midreset_held got stable %h rise %h want 00 00", swi_stable, swi_rise);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            checks++;
            if (swi_stable !== 8'h00) begin
                errors++;
                $display("FAIL midreset_edge%0d got %h want 00", k, swi_stable);
            end
        end
        tick(1);
        checks++;
        if (swi_stable !== 8'h04 || swi_rise !== 8'h04 || swi_changed !== 1'b1) begin
            errors++;
            $display("FAIL midreset_edge6 got stable %h rise %h chg %b want 04 04 1", swi_stable, swi_rise, swi_changed);
        end
    endtask

    task automatic test_min_debounce;
        swi_raw = 8'h00;
        tick(10);
        swi_raw = 8'h40;
        tick(2);
        checks++;
        if (stable1 !== 8'h00) begin
            errors++;
            $display("FAIL min_edge2 got %h want 00", stable1);
        end
        tick(1);
        checks++;
        if (stable1 !== 8'h40 || rise1 !== 8'h40 || changed1 !== 1'b1) begin
            errors++;
            $display("FAIL min_edge3 got stable %h rise %h chg %b want 40 40 1", stable1, rise1, changed1);
        end
        swi_raw = 8'h00;
        tick(3);
        checks++;
        if (stable1 !== 8'h00 || fall1 !== 8'h40) begin
            errors++;
            $display("FAIL min_release got stable %h fall %h want 00 40", stable1, fall1);
        end
    endtask

    task automatic test_toggle;
        logic [7:0] exp_on;
`ifdef SWI_TOGGLE_EN
        exp_on = 8'h20;
`else
        exp_on = 8'h00;
`endif
        swi_raw = 8'h00;
        tick(10);
        swi_raw = 8'h20;
        tick(5);
        checks++;
        if (swi_toggle !== 8'h00) begin
            errors++;
            $display("FAIL toggle_press1_edge5 got %h want 00", swi_toggle);
        end
        tick(1);
        checks++;
        if (swi_toggle !== exp_on) begin
            errors++;
            $display("FAIL toggle_press1_edge6 got %h want %h", swi_toggle, exp_on);
        end
        tick(4);
        swi_raw = 8'h00;
        tick(10);
        checks++;
        if (swi_toggle !== exp_on || swi_stable !== 8'h00) begin
            errors++;
            $display("FAIL toggle_release1 got toggle %h stable %h want %h 00", swi_toggle, swi_stable, exp_on);
        end
        swi_raw = 8'h20;
        tick(5);
        checks++;
        if (swi_toggle !== exp_on) begin
            errors++;
            $display("FAIL toggle_press2_edge5 got %h want %h", swi_toggle, exp_on);
        end
        tick(1);
        checks++;
        if (swi_toggle !== 8'h00) begin
            errors++;
            $display("FAIL toggle_press2_edge6 got %h want 00", swi_toggle);
        end
        swi_raw = 8'h00;
        tick(10);
        checks++;
        if (swi_toggle !== 8'h00) begin
            errors++;
            $display("FAIL toggle_release2 got %h want 00", swi_toggle);
        end
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_glitch;
        test_simultaneous;
        test_reset_midcount;
        test_min_debounce;
        test_toggle;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
